// File: rtl/sprite_rom_arbiter.sv
// Round-robin share of one registered sprite ROM; grant-to-response latency 2 cycles, no response back-pressure.
// Define SPRITE_ARB_DOODLE_PRIO_EN to give requester 0 fixed absolute priority over the rotation.
module sprite_rom_arbiter #(
  parameter int         N_REQ  = 4,
  parameter int         W      = 32,
  parameter int         H      = 32,
  parameter int         AW     = 16,
  parameter logic [7:0] TRANSP = 8'h00
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               frame_start,
  input  logic [N_REQ-1:0]   req_valid,
  input  logic [8*N_REQ-1:0] req_x,
  input  logic [8*N_REQ-1:0] req_y,
  output logic [N_REQ-1:0]   req_ready,
  output logic [AW-1:0]      rom_addr,
  input  logic [7:0]         rom_data,
  output logic               rsp_valid,
  output logic [2:0]         rsp_tag,
  output logic [7:0]         rsp_data,
  output logic               rsp_oob
);

  logic [2:0]  rr_ptr;
  logic [2:0]  ptr_nxt;
  logic [2:0]  gnt_idx;
  logic        gnt_any;
  logic        ptr_upd;
  int          idx;
  logic [7:0]  sel_x;
  logic [7:0]  sel_y;
  logic [15:0] lin_addr;
  logic        oob;

  logic        s1_valid;
  logic [2:0]  s1_tag;
  logic        s1_oob;
  logic        s2_valid;
  logic [2:0]  s2_tag;
  logic        s2_oob;

  // First requesting index at or after rr_ptr, wrapping, wins.
  always_comb begin
    gnt_any = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = (int'(rr_ptr) + k) % N_REQ;
      if (!gnt_any && req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_idx = 3'(idx);
      end
    end
`ifdef SPRITE_ARB_DOODLE_PRIO_EN
    if (req_valid[0]) begin
      gnt_any = 1'b1;
      gnt_idx = '0;
    end
    ptr_upd = gnt_any && !req_valid[0];
`else
    ptr_upd = gnt_any;
`endif
  end

  always_comb begin
    req_ready = gnt_any ? (N_REQ'(1) << gnt_idx) : '0;
    ptr_nxt   = (int'(gnt_idx) == N_REQ - 1) ? 3'd0 : gnt_idx + 3'd1;
    sel_x     = req_x[8*gnt_idx +: 8];
    sel_y     = req_y[8*gnt_idx +: 8];
    lin_addr  = 16'(sel_y) * 16'(W) + 16'(sel_x);
    oob       = (int'({24'd0, sel_x}) >= W) || (int'({24'd0, sel_y}) >= H);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      rom_addr <= '0;
      s1_valid <= 1'b0;
      s1_tag   <= '0;
      s1_oob   <= 1'b0;
      s2_valid <= 1'b0;
      s2_tag   <= '0;
      s2_oob   <= 1'b0;
    end else begin
      if (frame_start) begin
        rr_ptr <= '0;
      end else if (ptr_upd) begin
        rr_ptr <= ptr_nxt;
      end
      s1_valid <= gnt_any;
      if (gnt_any) begin
        s1_tag <= gnt_idx;
        s1_oob <= oob;
        // Out-of-range reads leave the ROM address alone; their data is replaced anyway.
        if (!oob) begin
          rom_addr <= AW'(lin_addr);
        end
      end
      s2_valid <= s1_valid;
      s2_tag   <= s1_tag;
      s2_oob   <= s1_oob;
    end
  end

  always_comb begin
    rsp_valid = s2_valid;
    rsp_tag   = s2_tag;
    rsp_oob   = s2_oob;
    rsp_data  = s2_oob ? TRANSP : rom_data;
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Directed bench for sprite_rom_arbiter with a behavioural ROM and a response scoreboard.
module tb_sprite_rom_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        frame_start;
  logic [3:0]  req_valid;
  logic [31:0] req_x;
  logic [31:0] req_y;
  logic [3:0]  req_ready;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data;
  logic        rsp_valid;
  logic [2:0]  rsp_tag;
  logic [7:0]  rsp_data;
  logic        rsp_oob;

  logic [7:0]  xs [4];
  logic [7:0]  ys [4];
  int          total = 0;
  int          bad = 0;
  int          cyc = 0;
  logic        mon_en = 1'b0;
  logic [15:0] last_addr = 16'd0;

  typedef struct {
    logic [2:0] tag;
    logic [7:0] data;
    logic       oob;
    int         due;
  } exp_t;
  exp_t sb [$];

  assign req_x = {xs[3], xs[2], xs[1], xs[0]};
  assign req_y = {ys[3], ys[2], ys[1], ys[0]};

  sprite_rom_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .req_valid   (req_valid),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_ready   (req_ready),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .rsp_valid   (rsp_valid),
    .rsp_tag     (rsp_tag),
    .rsp_data    (rsp_data),
    .rsp_oob     (rsp_oob)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] rom_f(input logic [15:0] a);
    return 8'(a * 16'd37 + 16'd11);
  endfunction

  always @(posedge clk) rom_data <= rom_f(rom_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [3:0] oh);
    exp_t        e;
    int          i = 0;
    logic [15:0] a;
    for (int k = 0; k < 4; k++) if (oh[k]) i = k;
    e.tag  = 3'(i);
    e.oob  = (xs[i] >= 8'd32) || (ys[i] >= 8'd32);
    a      = 16'(ys[i]) * 16'd32 + 16'(xs[i]);
    e.data = e.oob ? 8'h00 : rom_f(a);
    if (!e.oob) last_addr = a;
    e.due  = cyc + 2;
    sb.push_back(e);
  endtask

  task automatic step(input logic [3:0] exp_rdy);
    @(negedge clk);
    chk("req_ready", 32'(req_ready), 32'(exp_rdy));
    if (reset) begin
      while (sb.size() > 0 && sb[$].due > cyc) void'(sb.pop_back());
      last_addr = 16'd0;
    end else if (exp_rdy != 4'b0000) begin
      push(exp_rdy);
    end
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rsp_valid", 32'(rsp_valid), 32'd1);
        chk("rsp_tag",   32'(rsp_tag),   32'(sb[0].tag));
        chk("rsp_data",  32'(rsp_data),  32'(sb[0].data));
        chk("rsp_oob",   32'(rsp_oob),   32'(sb[0].oob));
        void'(sb.pop_front());
      end else begin
        chk("rsp_idle", 32'(rsp_valid), 32'd0);
      end
    end
  end

  initial begin
    reset       = 1'b1;
    frame_start = 1'b0;
    req_valid   = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'(i);
      ys[i] = 8'(i);
    end

    // Reset held with everyone requesting: grant still visible, nothing enters the pipe.
    step(4'b0001);
    mon_en = 1'b1;
    step(4'b0001);
    step(4'b0001);
    reset     = 1'b0;
    req_valid = 4'b0000;
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rsp_tag", 32'(rsp_tag), 32'd0);
    chk("rst_rsp_oob", 32'(rsp_oob), 32'd0);
    step(4'b0000);
    step(4'b0000);

    // Lone requester 2 at (5,3).
    xs[2] = 8'd5;
    ys[2] = 8'd3;
    req_valid = 4'b0100;
    step(4'b0100);
    req_valid = 4'b0000;
    chk("addr_101", 32'(rom_addr), 32'd101);
    step(4'b0000);
    step(4'b0000);

    // Rotation with all four requesting after a frame restart.
    frame_start = 1'b1;
    step(4'b0000);
    frame_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      xs[i] = 8'(3 * i + 1);
      ys[i] = 8'(5 * i + 2);
    end
    req_valid = 4'b1111;
    for (int k = 0; k < 8; k++) step(4'b0001 << (k % 4));
    req_valid = 4'b0000;

    // Out-of-range x on requester 1.
    xs[1] = 8'd40;
    ys[1] = 8'd0;
    req_valid = 4'b0010;
    step(4'b0010);
    req_valid = 4'b0000;
    chk("oob_addr_hold", 32'(rom_addr), 32'(last_addr));
    chk("oob_addr_554", 32'(rom_addr), 32'd554);
    step(4'b0000);
    step(4'b0000);

    // rr_ptr is 2; frame_start does not block this grant but resets the pointer.
    req_valid   = 4'b1011;
    frame_start = 1'b1;
    step(4'b1000);
    frame_start = 1'b0;
    step(4'b0001);
    xs[1] = 8'd4;
    ys[1] = 8'd31;

    // Single requester held continuously.
    req_valid = 4'b0010;
    step(4'b0010);
    step(4'b0010);
    step(4'b0010);

    req_valid = 4'b1111;
`ifdef SPRITE_ARB_DOODLE_PRIO_EN
    for (int k = 0; k < 4; k++) step(4'b0001);
`else
    step(4'b0100);
    step(4'b1000);
    step(4'b0001);
    step(4'b0010);
`endif
    req_valid = 4'b1110;
    step(4'b0100);
    step(4'b1000);
    step(4'b0010);

    // Reset in the middle of a burst drops responses still in flight.
    step(4'b0100);
    step(4'b1000);
    reset = 1'b1;
    step(4'b0010);
    reset     = 1'b0;
    req_valid = 4'b0000;
    chk("midrst_rom_addr", 32'(rom_addr), 32'd0);
    chk("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
    step(4'b0000);
    step(4'b0000);
    step(4'b0000);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
